// File: rtl/tlb_pkg.sv
// Shared types and field layout for the TLB maintenance sequencer.
// Entry layout is {valid, pid[11:0] | vpn[19:0], ppn[5:0]}.
package tlb_pkg;

   localparam int ENTRIES = 8;
   localparam int IDX_W   = 3;
   localparam int KEY_W   = 32;
   localparam int VAL_W   = 6;
   localparam int ENTRY_W = 1 + KEY_W + VAL_W;

   localparam int VALID_BIT = 38;
   localparam int KEY_HI    = 37;
   localparam int KEY_LO    = 6;
   localparam int VAL_HI    = 5;
   localparam int VAL_LO    = 0;
   localparam int PID_HI    = 31;
   localparam int PID_LO    = 20;

   typedef enum logic [2:0] {
      OP_PROBE     = 3'd0,
      OP_WRITE     = 3'd1,
      OP_CLEAR_ALL = 3'd2,
      OP_FLUSH_PID = 3'd3,
      OP_FLUSH_KEY = 3'd4
   } tlb_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_COMMIT,
      S_CLR,
      S_RESP
   } tlb_state_e;

   function automatic logic op_legal(logic [2:0] op);
      return op <= 3'd4;
   endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Picks the insert slot for a missing WRITE: lowest invalid entry
// seen during the scan, else the round-robin eviction pointer.
module tlb_victim_sel
   import tlb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic             scan_start,
   input  logic [IDX_W-1:0] scan_idx,
   input  logic             entry_valid,
   input  logic             commit,
   output logic [IDX_W-1:0] target
);

   logic [IDX_W-1:0] evict_ptr;
   logic [IDX_W-1:0] first_inv;
   logic             found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evict_ptr <= '0;
         first_inv <= '0;
         found     <= 1'b0;
      end else if (clk_en) begin
         if (scan_start) begin
            found <= 1'b0;
         end else if (!entry_valid && !found) begin
            found     <= 1'b1;
            first_inv <= scan_idx;
         end
         // pointer only moves when a valid entry is actually evicted
         if (commit && !found)
            evict_ptr <= evict_ptr + 1'b1;
      end
   end

   assign target = found ? first_inv : evict_ptr;

endmodule

// File: rtl/tlb_ctrl.sv
// TLB maintenance sequencer: probe, insert, clear and flush ops
// scanned through one indexed read/write port.
module tlb_ctrl
   import tlb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clk_en,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         req_op,
   input  logic [KEY_W-1:0]   req_key,
   input  logic [VAL_W-1:0]   req_value,
   output logic               resp_valid,
   output logic               resp_hit,
   output logic               resp_err,
   output logic [IDX_W-1:0]   resp_index,
   output logic [VAL_W-1:0]   resp_value,
   output logic               busy,
   output logic [IDX_W-1:0]   tlb_idx,
   input  logic [ENTRY_W-1:0] tlb_rd_entry,
   output logic               tlb_we,
   output logic [ENTRY_W-1:0] tlb_wdata,
   output logic               tlb_clear
);

   tlb_state_e       state_q, state_d;
   logic [2:0]       op_q;
   logic [KEY_W-1:0] key_q;
   logic [VAL_W-1:0] val_q;
   logic [IDX_W-1:0] scan_q, scan_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [VAL_W-1:0] rv_q, rv_d;
   logic             hit_q, hit_d;
   logic             err_q, err_d;

   logic             accept;
   logic             ent_valid;
   logic             key_match;
   logic             pid_match;
   logic             match;
   logic             last;
   logic             commit;
   logic             vs_valid;
   logic [IDX_W-1:0] target;

   assign accept    = (state_q == S_IDLE) && req_valid;
   assign ent_valid = tlb_rd_entry[VALID_BIT];
   assign key_match = ent_valid &&
      (tlb_rd_entry[KEY_HI:KEY_LO] == key_q);
   assign pid_match = ent_valid &&
      (tlb_rd_entry[KEY_LO+PID_HI:KEY_LO+PID_LO] ==
       key_q[PID_HI:PID_LO]);
   assign match  = (state_q == S_SCAN) &&
      ((op_q == OP_FLUSH_PID) ? pid_match : key_match);
   assign last   = scan_q == IDX_W'(ENTRIES - 1);
   assign commit = state_q == S_COMMIT;
   // outside SCAN nothing should look like a free slot
   assign vs_valid = (state_q != S_SCAN) || ent_valid;

   tlb_victim_sel u_victim (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_en      (clk_en),
      .scan_start  (accept),
      .scan_idx    (scan_q),
      .entry_valid (vs_valid),
      .commit      (commit),
      .target      (target)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         key_q   <= '0;
         val_q   <= '0;
         scan_q  <= '0;
         idx_q   <= '0;
         rv_q    <= '0;
         hit_q   <= 1'b0;
         err_q   <= 1'b0;
      end else if (clk_en) begin
         state_q <= state_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         rv_q    <= rv_d;
         hit_q   <= hit_d;
         err_q   <= err_d;
         if (accept) begin
            op_q  <= req_op;
            key_q <= req_key;
            val_q <= req_value;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      scan_d    = scan_q;
      idx_d     = idx_q;
      rv_d      = rv_q;
      hit_d     = hit_q;
      err_d     = err_q;
      tlb_idx   = '0;
      tlb_we    = 1'b0;
      tlb_wdata = '0;
      tlb_clear = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               scan_d = '0;
               idx_d  = '0;
               rv_d   = '0;
               hit_d  = 1'b0;
               err_d  = !op_legal(req_op);
               unique case (1'b1)
                  !op_legal(req_op):        state_d = S_RESP;
                  req_op == OP_CLEAR_ALL:   state_d = S_CLR;
                  default:                  state_d = S_SCAN;
               endcase
            end
         end
         S_SCAN: begin
            tlb_idx = scan_q;
            scan_d  = scan_q + 1'b1;
            if (match) begin
               hit_d = 1'b1;
               idx_d = scan_q;
               unique case (1'b1)
                  op_q == OP_WRITE: begin
                     tlb_we    = 1'b1;
                     tlb_wdata = {1'b1, key_q, val_q};
                  end
                  op_q == OP_PROBE: begin
                     rv_d = tlb_rd_entry[VAL_HI:VAL_LO];
                  end
                  default: begin
                     tlb_we    = 1'b1;
                     tlb_wdata = {1'b0, tlb_rd_entry[KEY_HI:0]};
                  end
               endcase
            end
            if (match && op_q != OP_FLUSH_PID)
               state_d = S_RESP;
            else if (last)
               state_d = (op_q == OP_WRITE) ? S_COMMIT : S_RESP;
         end
         S_COMMIT: begin
            tlb_idx   = target;
            tlb_we    = 1'b1;
            tlb_wdata = {1'b1, key_q, val_q};
            idx_d     = target;
            state_d   = S_RESP;
         end
         S_CLR: begin
            tlb_clear = 1'b1;
            state_d   = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready  = state_q == S_IDLE;
   assign busy       = state_q != S_IDLE;
   assign resp_valid = state_q == S_RESP;
   assign resp_hit   = resp_valid && hit_q;
   assign resp_err   = resp_valid && err_q;
   assign resp_index = resp_valid ? idx_q : '0;
   assign resp_value = resp_valid ? rv_q : '0;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Randomised and directed bench for tlb_ctrl with a bench-owned
// TLB array and an op-level reference model.
module tb_tlb_ctrl;
   import tlb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_en = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = '0;
   logic [31:0] req_key = '0;
   logic [5:0]  req_value = '0;
   logic        resp_valid, resp_hit, resp_err;
   logic [2:0]  resp_index;
   logic [5:0]  resp_value;
   logic        busy;
   logic [2:0]  tlb_idx;
   logic [38:0] tlb_rd_entry;
   logic        tlb_we;
   logic [38:0] tlb_wdata;
   logic        tlb_clear;

   logic [38:0] mem [8] = '{default: '0};
   logic [38:0] ref_tlb [8] = '{default: '0};
   int          ref_evict = 0;

   int          total = 0;
   int          bad = 0;

   int          e_lat, g_lat, g_hold, g_both;
   logic        e_hit, e_err, g_hit, g_err;
   logic [2:0]  e_idx, g_idx;
   logic [5:0]  e_val, g_val;
   logic [31:0] e_wem, e_clm, g_wem, g_clm;

   tlb_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clk_en       (clk_en),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_key      (req_key),
      .req_value    (req_value),
      .resp_valid   (resp_valid),
      .resp_hit     (resp_hit),
      .resp_err     (resp_err),
      .resp_index   (resp_index),
      .resp_value   (resp_value),
      .busy         (busy),
      .tlb_idx      (tlb_idx),
      .tlb_rd_entry (tlb_rd_entry),
      .tlb_we       (tlb_we),
      .tlb_wdata    (tlb_wdata),
      .tlb_clear    (tlb_clear)
   );

   always #5 clk = ~clk;

   assign tlb_rd_entry = mem[tlb_idx];

   always @(posedge clk) begin
      if (clk_en) begin
         if (tlb_clear) begin
            for (int i = 0; i < 8; i++) mem[i][38] <= 1'b0;
         end else if (tlb_we) begin
            mem[tlb_idx] <= tlb_wdata;
         end
      end
   end

   function automatic int find(input logic [31:0] key);
      for (int i = 0; i < 8; i++)
         if (ref_tlb[i][38] && ref_tlb[i][37:6] == key) return i;
      return -1;
   endfunction

   function automatic int mem_diff();
      int n = 0;
      for (int i = 0; i < 8; i++)
         if (mem[i] !== ref_tlb[i]) n++;
      return n;
   endfunction

   // Op-level model: latency in cycles after acceptance, response
   // fields, and which cycles write or clear the TLB.
   task automatic predict(input logic [2:0] op,
                          input logic [31:0] key,
                          input logic [5:0] val);
      int f, t;
      e_lat = 9; e_hit = 0; e_err = 0; e_idx = 0; e_val = 0;
      e_wem = 0; e_clm = 0;
      f = find(key);
      case (op)
         3'd0: if (f >= 0) begin
            e_hit = 1; e_idx = 3'(f); e_val = ref_tlb[f][5:0];
            e_lat = f + 2;
         end
         3'd1: if (f >= 0) begin
            ref_tlb[f] = {1'b1, key, val};
            e_hit = 1; e_idx = 3'(f); e_lat = f + 2; e_wem[f+1] = 1;
         end else begin
            t = -1;
            for (int i = 0; i < 8; i++)
               if (!ref_tlb[i][38] && t < 0) t = i;
            if (t < 0) begin
               t = ref_evict;
               ref_evict = (ref_evict + 1) % 8;
            end
            ref_tlb[t] = {1'b1, key, val};
            e_idx = 3'(t); e_lat = 10; e_wem[9] = 1;
         end
         3'd2: begin
            for (int i = 0; i < 8; i++) ref_tlb[i][38] = 1'b0;
            e_lat = 2; e_clm[1] = 1;
         end
         3'd3: for (int i = 0; i < 8; i++) begin
            if (ref_tlb[i][38] && ref_tlb[i][37:26] == key[31:20]) begin
               ref_tlb[i][38] = 1'b0;
               e_hit = 1; e_idx = 3'(i); e_wem[i+1] = 1;
            end
         end
         3'd4: if (f >= 0) begin
            ref_tlb[f][38] = 1'b0;
            e_hit = 1; e_idx = 3'(f); e_wem[f+1] = 1; e_lat = f + 2;
         end
         default: begin
            e_lat = 1; e_err = 1;
         end
      endcase
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] key,
                        input logic [5:0] val, input int sa,
                        input int sl);
      int cyc, st;
      logic [2:0] held;
      g_lat = -1; g_hit = 0; g_err = 0; g_idx = 0; g_val = 0;
      g_wem = 0; g_clm = 0; g_hold = 0; g_both = 0; st = 0;
      @(negedge clk);
      req_valid = 1; req_op = op; req_key = key; req_value = val;
      @(negedge clk);
      req_valid = 0; req_op = 3'($urandom);
      req_key = $urandom; req_value = 6'($urandom);
      cyc = 1;
      while (cyc < 60) begin
         if (tlb_we && tlb_clear) g_both++;
         if (cyc - st < 32) begin
            if (tlb_we) g_wem[cyc-st] = 1'b1;
            if (tlb_clear) g_clm[cyc-st] = 1'b1;
         end
         if (resp_valid) begin
            g_lat = cyc; g_hit = resp_hit; g_err = resp_err;
            g_idx = resp_index; g_val = resp_value;
            break;
         end
         if (cyc == sa && sl > 0) begin
            held = tlb_idx;
            clk_en = 0;
            repeat (sl) begin
               @(negedge clk);
               cyc++; st++;
               if (tlb_idx !== held || resp_valid) g_hold++;
            end
            clk_en = 1;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] key,
                        input logic [5:0] val, input int sa,
                        input int sl);
      predict(op, key, val);
      issue(op, key, val, sa, sl);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({req_ready, busy, resp_valid, resp_hit, resp_err} !== 5'b10000)
         begin bad++;
         $display("FAIL reset_flags got=%b want=10000",
                  {req_ready, busy, resp_valid, resp_hit, resp_err}); end
      total++;
      if ({tlb_we, tlb_clear, tlb_idx, resp_index, resp_value} !== '0 ||
          tlb_wdata !== '0) begin bad++;
         $display("FAIL reset_tlb_outs we=%b clr=%b idx=%0d wd=%h want 0",
                  tlb_we, tlb_clear, tlb_idx, tlb_wdata); end
      rst_n = 1;
   endtask

   task automatic test_clear();
      do_op(3'd2, 0, 0, 0, 0);
      total++;
      if (g_lat !== 2 || g_err !== 0 || g_clm !== 32'h2 || g_wem !== 0)
         begin bad++;
         $display("FAIL clear lat=%0d err=%b clr=%h we=%h want 2 0 2 0",
                  g_lat, g_err, g_clm, g_wem); end
   endtask

   task automatic test_write_empty();
      do_op(3'd1, 32'h00100005, 6'h12, 0, 0);
      total++;
      if (g_lat !== 10 || g_hit !== 0 || g_idx !== 0 ||
          g_wem !== 32'h200) begin bad++;
         $display("FAIL write_empty lat=%0d hit=%b idx=%0d we=%h want 10 0 0 200",
                  g_lat, g_hit, g_idx, g_wem); end
      total++;
      if (mem_diff() != 0) begin bad++;
         $display("FAIL write_empty_mem diffs=%0d want 0", mem_diff()); end
   endtask

   task automatic test_evict();
      do_op(3'd2, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         do_op(3'd1, 32'h00200000 + i, 6'(i), 0, 0);
      for (int k = 0; k < 3; k++) begin
         do_op(3'd1, 32'h00300001 + k, 6'(k + 9), 0, 0);
         total++;
         if (g_idx !== 3'(k) || g_lat !== 10 || g_hit !== 0) begin bad++;
            $display("FAIL evict_%0d idx=%0d lat=%0d hit=%b want %0d 10 0",
                     k, g_idx, g_lat, g_hit, k); end
      end
      total++;
      if (mem_diff() != 0) begin bad++;
         $display("FAIL evict_mem diffs=%0d want 0", mem_diff()); end
   endtask

   task automatic test_write_hit();
      do_op(3'd2, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         do_op(3'd1, 32'h00500030 + i, 6'(i), 0, 0);
      do_op(3'd1, 32'h00500033, 6'h2A, 0, 0);
      total++;
      if (g_lat !== 5 || g_hit !== 1 || g_idx !== 3 ||
          g_wem !== 32'h10) begin bad++;
         $display("FAIL write_hit lat=%0d hit=%b idx=%0d we=%h want 5 1 3 10",
                  g_lat, g_hit, g_idx, g_wem); end
      do_op(3'd0, 32'h00500033, 0, 0, 0);
      total++;
      if (g_lat !== 5 || g_hit !== 1 || g_idx !== 3 || g_val !== 6'h2A)
         begin bad++;
         $display("FAIL probe_after_write lat=%0d hit=%b idx=%0d val=%h want 5 1 3 2a",
                  g_lat, g_hit, g_idx, g_val); end
   endtask

   task automatic test_flush_pid();
      logic [11:0] pids [7] = '{12'h2, 12'h1, 12'h2, 12'h3,
                                12'h1, 12'h2, 12'h1};
      do_op(3'd2, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++)
         do_op(3'd1, {pids[i], 20'(i)}, 6'(i), 0, 0);
      do_op(3'd3, 32'h00100000, 0, 0, 0);
      total++;
      if (g_lat !== 9 || g_hit !== 1 || g_idx !== 6 ||
          g_wem !== 32'hA4) begin bad++;
         $display("FAIL flush_pid lat=%0d hit=%b idx=%0d we=%h want 9 1 6 a4",
                  g_lat, g_hit, g_idx, g_wem); end
      total++;
      if (mem_diff() != 0) begin bad++;
         $display("FAIL flush_pid_mem diffs=%0d want 0", mem_diff()); end
   endtask

   task automatic test_illegal();
      for (int op = 5; op < 8; op++) begin
         do_op(3'(op), 32'h00100005, 6'h3F, 0, 0);
         total++;
         if (g_lat !== 1 || g_err !== 1 || g_hit !== 0 ||
             g_wem !== 0 || g_clm !== 0) begin bad++;
            $display("FAIL illegal_%0d lat=%0d err=%b we=%h clr=%h want 1 1 0 0",
                     op, g_lat, g_err, g_wem, g_clm); end
      end
   endtask

   task automatic test_clk_en();
      do_op(3'd0, 32'h0FF00000, 0, 3, 3);
      total++;
      if (g_lat !== e_lat + 3 || g_hit !== 0 || g_hold !== 0) begin bad++;
         $display("FAIL clk_en_hold lat=%0d hit=%b holdbad=%0d want %0d 0 0",
                  g_lat, g_hit, g_hold, e_lat + 3); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         do_op(3'd0, 32'h00100000 + k, 0, 0, 0);
         total++;
         if (req_ready !== 0 || g_lat !== e_lat || g_hit !== e_hit ||
             g_idx !== e_idx || g_val !== e_val) begin bad++;
            $display("FAIL b2b_resp_%0d rdy=%b lat=%0d hit=%b idx=%0d want 0 %0d %b %0d",
                     k, req_ready, g_lat, g_hit, g_idx, e_lat, e_hit, e_idx); end
         @(negedge clk);
         total++;
         if (req_ready !== 1 || busy !== 0) begin bad++;
            $display("FAIL b2b_gap_%0d rdy=%b busy=%b want 1 0",
                     k, req_ready, busy); end
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      do_op(3'd2, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         do_op(3'd1, 32'h00700000 | i, 6'(i), 0, 0);
      @(negedge clk);
      req_valid = 1; req_op = 3'd3; req_key = 32'h00700000;
      @(negedge clk);
      req_valid = 0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (tlb_we !== 1 || tlb_idx !== 2) begin bad++;
         $display("FAIL mid_scan_pre we=%b idx=%0d want 1 2", tlb_we, tlb_idx); end
      rst_n = 0;
      #1;
      total++;
      if (busy !== 0 || tlb_we !== 0 || resp_valid !== 0 || req_ready !== 1)
         begin bad++;
         $display("FAIL mid_scan_reset busy=%b we=%b rv=%b rdy=%b want 0 0 0 1",
                  busy, tlb_we, resp_valid, req_ready); end
      ref_tlb[0][38] = 1'b0;
      ref_tlb[1][38] = 1'b0;
      ref_evict = 0;
      seen = 0;
      repeat (2) @(negedge clk) if (resp_valid) seen = 1;
      rst_n = 1;
      repeat (12) @(negedge clk) if (resp_valid) seen = 1;
      total++;
      if (seen !== 0) begin bad++;
         $display("FAIL mid_scan_noresp got=%b want 0", seen); end
      total++;
      if (mem_diff() != 0) begin bad++;
         $display("FAIL mid_scan_mem diffs=%0d want 0", mem_diff()); end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] key;
      int r, sl, xl;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 15);
         if (r < 4) op = 3'd0;
         else if (r < 9) op = 3'd1;
         else if (r < 10) op = 3'd2;
         else if (r < 12) op = 3'd3;
         else if (r < 14) op = 3'd4;
         else op = 3'($urandom_range(5, 7));
         key = {12'($urandom_range(1, 3)), 20'($urandom_range(0, 5))};
         sl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
         do_op(op, key, 6'($urandom), 1, sl);
         xl = e_lat + ((e_lat > 1) ? sl : 0);
         total++;
         if (g_lat !== xl || g_hit !== e_hit || g_err !== e_err ||
             g_idx !== e_idx || g_val !== e_val) begin bad++;
            $display("FAIL rand_resp_%0d op=%0d lat/hit/err/idx/val=%0d %b %b %0d %h want %0d %b %b %0d %h",
                     n, op, g_lat, g_hit, g_err, g_idx, g_val,
                     xl, e_hit, e_err, e_idx, e_val); end
         total++;
         if (g_wem !== e_wem || g_clm !== e_clm || g_both != 0 ||
             g_hold != 0) begin bad++;
            $display("FAIL rand_port_%0d op=%0d we=%h clr=%h both=%0d hold=%0d want %h %h 0 0",
                     n, op, g_wem, g_clm, g_both, g_hold, e_wem, e_clm); end
         total++;
         if (mem_diff() != 0) begin bad++;
            $display("FAIL rand_mem_%0d op=%0d diffs=%0d want 0",
                     n, op, mem_diff()); end
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_write_empty();
      test_evict();
      test_write_hit();
      test_flush_pid();
      test_illegal();
      test_clk_en();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
